matmul_mac_ctrl: RTL

Multiply-accumulate sequencer that computes C = A x B for two 8x8 signed matrices held in row-major input RAMs (A RAM, B RAM).
It feeds the 64 x 19-bit signed result RAM directly downstream through that RAM's write port (addr, mdi, mwr), one element per write.
Both input RAMs are synchronous-read with 1-cycle latency: address presented in cycle t, data valid in cycle t+1.
Started by a single-cycle start pulse; reports busy and done.

---
 rtl/matmul_mac_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/matmul_mac_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_mac_ctrl
//
// Multiply-accumulate sequencer computing C = A x B for two 8x8 signed
// matrices stored row-major in synchronous-read RAMs (1-cycle read latency).
// Each result element takes 10 cycles: 8 FETCH cycles issuing the k = 0..7
// operand reads, one ACC cycle to fold in the last product, and one WRITE
// cycle presenting the element to the result RAM write port. Elements are
// produced in ascending address order 0..63. A one-cycle DONE state follows
// the 64th write.
//
// Build option:
//   MATMUL_TRANSPOSE_B_EN  when defined, B is read transposed
//                          (b_addr = j*8+k), giving C = A x B^T.
//                          Timing is identical in both builds.
//
// Ports:
//   clk     in   clock, all state on the rising edge
//   reset   in   asynchronous active-high reset, clears all state
//   start   in   one-cycle request to begin, only honoured in IDLE
//   busy    out  high in every state except IDLE
//   done    out  one-cycle pulse after the last result write
//   a_addr  out  A RAM read address (i*8+k)
//   a_data  in   signed A element, valid one cycle after a_addr
//   b_addr  out  B RAM read address (k*8+j, or j*8+k when transposed)
//   b_data  in   signed B element, valid one cycle after b_addr
//   c_addr  out  result RAM write address (i*8+j)
//   c_mdi   out  signed result data
//   c_mwr   out  result RAM write enable
//
// State table:
//   IDLE  | waiting for start; indices and accumulator at zero
//   FETCH | issue A/B reads for k = 0..7, accumulate delayed products
//   ACC   | accumulate the k = 7 product, latch the result element
//   WRITE | result element on the write port; step j (and i on wrap)
//   DONE  | one-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module matmul_mac_ctrl #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 19,
  parameter int N      = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic [ADDR_W-1:0] c_addr,
  output logic [ACC_W-1:0]  c_mdi,
  output logic              c_mwr
);

  // Row/column/inner indices each take half of the RAM address.
  localparam int IDX_W  = ADDR_W / 2;
  localparam int PROD_W = 2 * DATA_W;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ACC   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         i_q, i_d;
  logic [IDX_W-1:0]         j_q, j_d;
  logic [IDX_W-1:0]         k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     valid_q, valid_d;
  logic [ADDR_W-1:0]        c_addr_q, c_addr_d;
  logic [ACC_W-1:0]         c_mdi_q, c_mdi_d;
  logic                     c_mwr_q, c_mwr_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_next;
  logic                     last_elem;

  // Operands are widened to the product width first so the multiply is a
  // plain same-width signed multiply; the low PROD_W bits hold the exact
  // product because |a*b| <= 2^14.
  assign a_ext    = {{DATA_W{a_data[DATA_W-1]}}, a_data};
  assign b_ext    = {{DATA_W{b_data[DATA_W-1]}}, b_data};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign acc_sum  = acc_q + prod_ext;

  // valid_q marks the cycle in which RAM data for a FETCH address arrives.
  assign acc_next  = valid_q ? acc_sum : acc_q;
  assign last_elem = (i_q == IDX_LAST) && (j_q == IDX_LAST);

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    valid_d  = (state_q == S_FETCH);
    c_addr_d = c_addr_q;
    c_mdi_d  = c_mdi_q;
    c_mwr_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          i_d     = IDX_ZERO;
          j_d     = IDX_ZERO;
          k_d     = IDX_ZERO;
          acc_d   = '0;
        end
      end

      S_FETCH: begin
        acc_d = acc_next;
        k_d   = k_q + IDX_ONE;
        if (k_q == IDX_LAST) begin
          state_d = S_ACC;
        end
      end

      S_ACC: begin
        // Result is latched here so it sits on the port during WRITE.
        acc_d    = acc_next;
        c_mwr_d  = 1'b1;
        c_addr_d = {i_q, j_q};
        c_mdi_d  = acc_next;
        state_d  = S_WRITE;
      end

      S_WRITE: begin
        acc_d = '0;
        k_d   = IDX_ZERO;
        j_d   = j_q + IDX_ONE;
        if (j_q == IDX_LAST) begin
          i_d = i_q + IDX_ONE;
        end
        state_d = last_elem ? S_DONE : S_FETCH;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      valid_q  <= 1'b0;
      c_addr_q <= '0;
      c_mdi_q  <= '0;
      c_mwr_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      valid_q  <= valid_d;
      c_addr_q <= c_addr_d;
      c_mdi_q  <= c_mdi_d;
      c_mwr_q  <= c_mwr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Read addresses are straight concatenations of the index registers.
  assign a_addr = {i_q, k_q};
`ifdef MATMUL_TRANSPOSE_B_EN
  assign b_addr = {j_q, k_q};
`else
  assign b_addr = {k_q, j_q};
`endif

  assign c_addr = c_addr_q;
  assign c_mdi  = c_mdi_q;
  assign c_mwr  = c_mwr_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
